// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA channel sequencer.
package dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_WAIT_RD,
    S_WR,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [2:0] REG_SRC_L  = 3'd0;
  localparam logic [2:0] REG_SRC_H  = 3'd1;
  localparam logic [2:0] REG_DST_L  = 3'd2;
  localparam logic [2:0] REG_DST_H  = 3'd3;
  localparam logic [2:0] REG_LEN_L  = 3'd4;
  localparam logic [2:0] REG_LEN_H  = 3'd5;
  localparam logic [2:0] REG_CTRL   = 3'd6;
  localparam logic [2:0] REG_STATUS = 3'd7;

  localparam int CTRL_START   = 0;
  localparam int CTRL_SRC_IO  = 1;
  localparam int CTRL_DST_IO  = 2;
  localparam int CTRL_SRC_INC = 3;
  localparam int CTRL_DST_INC = 4;
  localparam int CTRL_IRQ_EN  = 5;
  localparam int CTRL_FILL    = 6;
  localparam int CTRL_ABORT   = 7;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

  typedef struct packed {
    logic irq_en;
    logic dst_inc;
    logic src_inc;
    logic dst_io;
    logic src_io;
  } cfg_t;

endpackage

// File: rtl/dma_regfile.sv
// CPU register window: strobe edge-detect, storage and read mux.
// Fill-mode bit exists only when DMA_CHANNEL_FILL_EN is defined.
module dma_regfile
  import dma_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_cs_n,
  input  logic              cpu_wr_n,
  input  logic              cpu_rd_n,
  input  logic [2:0]        cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  input  logic              busy,
  input  logic              done,
  input  logic              aborted,
  input  logic              upd,
  input  logic [ADDR_W-1:0] src_nxt,
  input  logic [ADDR_W-1:0] dst_nxt,
  input  logic [LEN_W-1:0]  len_nxt,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [LEN_W-1:0]  len,
  output cfg_t              cfg,
`ifdef DMA_CHANNEL_FILL_EN
  output logic              fill_en,
`endif
  output logic              start,
  output logic              abort,
  output logic              st_clr
);

  logic        wr_n_q;
  logic        wr_fire;
  logic [15:0] src16;
  logic [15:0] dst16;
  logic [15:0] len16;
  logic [7:0]  rdata;
  logic [7:0]  ctrl_rd;

  assign wr_fire = !cpu_cs_n && !cpu_wr_n && wr_n_q;
  assign start   = wr_fire && cpu_addr == REG_CTRL && cpu_din[CTRL_START];
  assign abort   = wr_fire && cpu_addr == REG_CTRL && cpu_din[CTRL_ABORT];
  assign st_clr  = wr_fire && cpu_addr == REG_STATUS && cpu_din[STAT_DONE];

  assign src16 = 16'(src);
  assign dst16 = 16'(dst);
  assign len16 = 16'(len);

  always_ff @(posedge clk) begin
    if (reset) wr_n_q <= 1'b1;
    else       wr_n_q <= cpu_wr_n;
  end

  // Config is frozen while busy so an ABORT write cannot alter IRQ_EN.
  always_ff @(posedge clk) begin
    if (reset) begin
      src <= '0;
      dst <= '0;
      len <= '0;
      cfg <= '0;
`ifdef DMA_CHANNEL_FILL_EN
      fill_en <= 1'b0;
`endif
    end else if (upd) begin
      src <= src_nxt;
      dst <= dst_nxt;
      len <= len_nxt;
    end else if (wr_fire && !busy) begin
      case (cpu_addr)
        REG_SRC_L: src <= ADDR_W'({src16[15:8], cpu_din});
        REG_SRC_H: src <= ADDR_W'({cpu_din, src16[7:0]});
        REG_DST_L: dst <= ADDR_W'({dst16[15:8], cpu_din});
        REG_DST_H: dst <= ADDR_W'({cpu_din, dst16[7:0]});
        REG_LEN_L: len <= LEN_W'({len16[15:8], cpu_din});
        REG_LEN_H: len <= LEN_W'({cpu_din, len16[7:0]});
        REG_CTRL: begin
          cfg.src_io  <= cpu_din[CTRL_SRC_IO];
          cfg.dst_io  <= cpu_din[CTRL_DST_IO];
          cfg.src_inc <= cpu_din[CTRL_SRC_INC];
          cfg.dst_inc <= cpu_din[CTRL_DST_INC];
          cfg.irq_en  <= cpu_din[CTRL_IRQ_EN];
`ifdef DMA_CHANNEL_FILL_EN
          fill_en     <= cpu_din[CTRL_FILL];
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_SRC_IO]  = cfg.src_io;
    ctrl_rd[CTRL_DST_IO]  = cfg.dst_io;
    ctrl_rd[CTRL_SRC_INC] = cfg.src_inc;
    ctrl_rd[CTRL_DST_INC] = cfg.dst_inc;
    ctrl_rd[CTRL_IRQ_EN]  = cfg.irq_en;
`ifdef DMA_CHANNEL_FILL_EN
    ctrl_rd[CTRL_FILL]    = fill_en;
`endif
  end

  always_comb begin
    rdata = '0;
    case (cpu_addr)
      REG_SRC_L: rdata = src16[7:0];
      REG_SRC_H: rdata = src16[15:8];
      REG_DST_L: rdata = dst16[7:0];
      REG_DST_H: rdata = dst16[15:8];
      REG_LEN_L: rdata = len16[7:0];
      REG_LEN_H: rdata = len16[15:8];
      REG_CTRL:  rdata = ctrl_rd;
      default: begin
        rdata[STAT_BUSY]    = busy;
        rdata[STAT_DONE]    = done;
        rdata[STAT_ABORTED] = aborted;
      end
    endcase
  end

  assign cpu_dout = (!cpu_cs_n && !cpu_rd_n) ? rdata : 8'h00;

endmodule

// File: rtl/dma_channel_ctrl.sv
// DMA channel sequencer feeding single-byte read/write ops to the engine.
// Define DMA_CHANNEL_FILL_EN to add fill mode (SRC_L is the fill byte).
module dma_channel_ctrl
  import dma_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_cs_n,
  input  logic              cpu_wr_n,
  input  logic              cpu_rd_n,
  input  logic [2:0]        cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  input  logic              busak_n,
  output logic              en_n,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [ADDR_W-1:0] op_addr,
  output logic [7:0]        op_data,
  output logic              op_write,
  output logic              op_io,
  input  logic              rd_valid,
  input  logic [7:0]        rd_data,
  output logic              irq_n
);

  state_t            state;
  state_t            nxt;
  cfg_t              cfg;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] src_nxt;
  logic [ADDR_W-1:0] dst_nxt;
  logic [LEN_W-1:0]  len_dec;
  logic [7:0]        rd_byte;
  logic              start;
  logic              abort;
  logic              st_clr;
  logic              busy;
  logic              upd;
  logic              done_q;
  logic              abort_q;
  logic              irq_q;
  logic              fill;

`ifdef DMA_CHANNEL_FILL_EN
  logic fill_en;
  assign fill = fill_en;
`else
  assign fill = 1'b0;
`endif

  assign busy = state inside {S_REQ, S_RD, S_WAIT_RD, S_WR, S_NEXT};
  assign upd  = state == S_NEXT && !busak_n && !abort;

  assign len_dec = len - 1'b1;
  assign src_nxt = fill ? src
                 : src + {{(ADDR_W-1){1'b0}}, cfg.src_inc};
  assign dst_nxt = dst + {{(ADDR_W-1){1'b0}}, cfg.dst_inc};

  dma_regfile #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_regs (
    .clk      (clk),
    .reset    (reset),
    .cpu_cs_n (cpu_cs_n),
    .cpu_wr_n (cpu_wr_n),
    .cpu_rd_n (cpu_rd_n),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .busy     (busy),
    .done     (done_q),
    .aborted  (abort_q),
    .upd      (upd),
    .src_nxt  (src_nxt),
    .dst_nxt  (dst_nxt),
    .len_nxt  (len_dec),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .cfg      (cfg),
`ifdef DMA_CHANNEL_FILL_EN
    .fill_en  (fill_en),
`endif
    .start    (start),
    .abort    (abort),
    .st_clr   (st_clr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      rd_byte <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_WAIT_RD && rd_valid) rd_byte <= rd_data;
      if (state == S_IDLE && start) begin
        done_q  <= 1'b0;
        abort_q <= 1'b0;
        irq_q   <= 1'b0;
      end
      if (abort && state != S_IDLE) abort_q <= 1'b1;
      if (state == S_DONE) begin
        done_q <= 1'b1;
        if (cfg.irq_en) irq_q <= 1'b1;
      end
      if (st_clr) begin
        done_q  <= 1'b0;
        abort_q <= 1'b0;
        irq_q   <= 1'b0;
      end
    end
  end

  // Progress stalls whenever the CPU has taken the bus back.
  always_comb begin
    nxt      = state;
    en_n     = 1'b1;
    op_valid = 1'b0;
    op_addr  = '0;
    op_data  = '0;
    op_write = 1'b0;
    op_io    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) nxt = (len == '0) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        en_n = 1'b0;
        if (!busak_n) nxt = fill ? S_WR : S_RD;
      end
      S_RD: begin
        en_n     = 1'b0;
        op_valid = 1'b1;
        op_addr  = src;
        op_io    = cfg.src_io;
        if (op_ready && !busak_n) nxt = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        en_n = 1'b0;
        if (rd_valid) nxt = S_WR;
      end
      S_WR: begin
        en_n     = 1'b0;
        op_valid = 1'b1;
        op_write = 1'b1;
        op_addr  = dst;
        op_data  = fill ? src[7:0] : rd_byte;
        op_io    = cfg.dst_io;
        if (op_ready && !busak_n) nxt = S_NEXT;
      end
      S_NEXT: begin
        en_n = 1'b0;
        if (!busak_n) begin
          if (len_dec == '0) nxt = S_DONE;
          else               nxt = fill ? S_WR : S_RD;
        end
      end
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (abort && busy) nxt = S_DONE;
  end

  assign irq_n = !irq_q;

endmodule

// File: tb/tb_dma_channel_ctrl.sv
// Scoreboard bench for dma_channel_ctrl with a simple engine/Z80 model.
module tb_dma_channel_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_cs_n, cpu_wr_n, cpu_rd_n;
  logic [2:0]  cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        busak_n;
  logic        en_n;
  logic        op_valid, op_ready;
  logic [15:0] op_addr;
  logic [7:0]  op_data;
  logic        op_write, op_io;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        irq_n;

  logic        stall_wr = 1'b0;
  assign op_ready = !stall_wr || !op_write;

  typedef struct {
    logic        w;
    logic        io;
    logic [15:0] a;
    logic [7:0]  d;
  } op_t;

  op_t        exp_q[$];
  logic [7:0] rd_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_rd = 0;
  int n_wr = 0;

  always #5 clk = ~clk;

  dma_channel_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_cs_n(cpu_cs_n), .cpu_wr_n(cpu_wr_n), .cpu_rd_n(cpu_rd_n),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .busak_n(busak_n), .en_n(en_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_addr(op_addr),
    .op_data(op_data), .op_write(op_write), .op_io(op_io),
    .rd_valid(rd_valid), .rd_data(rd_data), .irq_n(irq_n)
  );

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic void exp_op(logic w, logic io, logic [15:0] a,
                                 logic [7:0] d);
    op_t o;
    o.w = w; o.io = io; o.a = a; o.d = d;
    exp_q.push_back(o);
  endfunction

  // Z80 grants the bus one cycle after the request.
  initial begin
    busak_n = 1'b1;
    forever begin
      @(posedge clk); #1;
      busak_n = en_n;
    end
  end

  // Engine: read data returns the cycle after a read handshake.
  initial begin
    bit hs;
    rd_valid = 1'b0;
    rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      hs = op_valid && op_ready && !op_write;
      @(posedge clk); #1;
      rd_valid = 1'b0;
      if (hs && rd_q.size() > 0) begin
        rd_valid = 1'b1;
        rd_data  = rd_q.pop_front();
      end
    end
  end

  // Monitor: every accepted op is checked against the scoreboard.
  always @(negedge clk) begin
    if (!reset && op_valid && op_ready) begin
      if (op_write) n_wr++;
      else          n_rd++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_op: got w=%b addr=%h data=%h",
                 op_write, op_addr, op_data);
      end else begin
        op_t e;
        e = exp_q.pop_front();
        check("op_write", {31'd0, op_write}, {31'd0, e.w});
        check("op_addr", {16'd0, op_addr}, {16'd0, e.a});
        check("op_io", {31'd0, op_io}, {31'd0, e.io});
        check("op_en_n", {31'd0, en_n}, 32'd0);
        if (e.w) check("op_data", {24'd0, op_data}, {24'd0, e.d});
      end
    end
  end

  task automatic cpu_wr(logic [2:0] a, logic [7:0] d);
    @(posedge clk); #1;
    cpu_cs_n = 1'b0; cpu_wr_n = 1'b0; cpu_addr = a; cpu_din = d;
    @(posedge clk); #1;
    cpu_cs_n = 1'b1; cpu_wr_n = 1'b1;
  endtask

  task automatic rd_chk(string nm, logic [2:0] a, logic [7:0] exp);
    @(posedge clk); #1;
    cpu_cs_n = 1'b0; cpu_rd_n = 1'b0; cpu_addr = a;
    #2;
    check(nm, {24'd0, cpu_dout}, {24'd0, exp});
    cpu_cs_n = 1'b1; cpu_rd_n = 1'b1;
  endtask

  task automatic prog(logic [15:0] s, logic [15:0] d, logic [15:0] l,
                      logic [7:0] ctrl);
    cpu_wr(3'd0, s[7:0]);
    cpu_wr(3'd1, s[15:8]);
    cpu_wr(3'd2, d[7:0]);
    cpu_wr(3'd3, d[15:8]);
    cpu_wr(3'd4, l[7:0]);
    cpu_wr(3'd5, l[15:8]);
    cpu_wr(3'd6, ctrl);
  endtask

  task automatic wait_idle(string nm);
    int k = 0;
    while (en_n == 1'b0 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 500) check({nm, "_timeout"}, 32'd1, 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int w0, r0, k;
    reset = 1'b1;
    cpu_cs_n = 1'b1; cpu_wr_n = 1'b1; cpu_rd_n = 1'b1;
    cpu_addr = 3'd0; cpu_din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en_n", {31'd0, en_n}, 32'd1);
    check("rst_op_valid", {31'd0, op_valid}, 32'd0);
    check("rst_op_addr", {16'd0, op_addr}, 32'd0);
    check("rst_irq_n", {31'd0, irq_n}, 32'd1);
    check("rst_dout", {24'd0, cpu_dout}, 32'd0);
    reset = 1'b0;
    rd_chk("rst_status", 3'd7, 8'h00);

    // Basic three-byte copy.
    rd_q.push_back(8'h11); rd_q.push_back(8'h22); rd_q.push_back(8'h33);
    exp_op(0, 0, 16'h4000, 8'h00); exp_op(1, 0, 16'h8000, 8'h11);
    exp_op(0, 0, 16'h4001, 8'h00); exp_op(1, 0, 16'h8001, 8'h22);
    exp_op(0, 0, 16'h4002, 8'h00); exp_op(1, 0, 16'h8002, 8'h33);
    prog(16'h4000, 16'h8000, 16'd3, 8'h19);
    check("t1_en_low", {31'd0, en_n}, 32'd0);
    wait_idle("t1");
    check("t1_sb_empty", exp_q.size(), 0);
    rd_chk("t1_status", 3'd7, 8'h02);
    rd_chk("t1_src_l", 3'd0, 8'h03);
    rd_chk("t1_dst_l", 3'd2, 8'h03);
    rd_chk("t1_len_l", 3'd4, 8'h00);
    check("t1_irq_n", {31'd0, irq_n}, 32'd1);

    // Zero length: completes without a bus request.
    cpu_wr(3'd7, 8'h02);
    rd_chk("t2_status_clr", 3'd7, 8'h00);
    w0 = n_wr; r0 = n_rd;
    prog(16'h1234, 16'h5678, 16'd0, 8'h19);
    for (int i = 0; i < 3; i++) begin
      check("t2_en_n", {31'd0, en_n}, 32'd1);
      @(posedge clk); #1;
    end
    rd_chk("t2_status", 3'd7, 8'h02);
    check("t2_ops", n_wr + n_rd, w0 + r0);

    // Source wraps FFFF -> 0000, writes go to I/O space.
    rd_q.push_back(8'h5A); rd_q.push_back(8'h5B);
    exp_op(0, 0, 16'hFFFF, 8'h00); exp_op(1, 1, 16'h1000, 8'h5A);
    exp_op(0, 0, 16'h0000, 8'h00); exp_op(1, 1, 16'h1001, 8'h5B);
    prog(16'hFFFF, 16'h1000, 16'd2, 8'h1D);
    wait_idle("t3");
    check("t3_sb_empty", exp_q.size(), 0);
    rd_chk("t3_src_h", 3'd1, 8'h00);
    rd_chk("t3_src_l", 3'd0, 8'h01);

    // Write stalled five cycles by the engine.
    w0 = n_wr;
    stall_wr = 1'b1;
    rd_q.push_back(8'h77);
    exp_op(0, 0, 16'h2000, 8'h00); exp_op(1, 0, 16'h3000, 8'h77);
    prog(16'h2000, 16'h3000, 16'd1, 8'h19);
    k = 0;
    while (!(op_valid && op_write) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t4_wr_seen", {31'd0, op_valid && op_write}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", {31'd0, op_valid}, 32'd1);
      check("t4_hold_addr", {16'd0, op_addr}, 32'h3000);
      check("t4_hold_data", {24'd0, op_data}, 32'h77);
      check("t4_hold_write", {31'd0, op_write}, 32'd1);
    end
    @(posedge clk); #1;
    stall_wr = 1'b0;
    wait_idle("t4");
    check("t4_one_write", n_wr - w0, 1);
    check("t4_sb_empty", exp_q.size(), 0);

    // Abort after the first of four bytes.
    w0 = n_wr;
    rd_q.push_back(8'h99);
    exp_op(0, 0, 16'h5000, 8'h00); exp_op(1, 0, 16'h6000, 8'h99);
    exp_op(0, 0, 16'h5001, 8'h00);
    prog(16'h5000, 16'h6000, 16'd4, 8'h39);
    k = 0;
    while (n_wr == w0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("t5_first_wr", n_wr - w0, 1);
    repeat (4) @(posedge clk);
    cpu_wr(3'd6, 8'h80);
    check("t5_en_n", {31'd0, en_n}, 32'd1);
    check("t5_op_valid", {31'd0, op_valid}, 32'd0);
    repeat (2) @(posedge clk);
    rd_chk("t5_status", 3'd7, 8'h06);
    rd_chk("t5_len_l", 3'd4, 8'h03);
    rd_chk("t5_src_l", 3'd0, 8'h01);
    check("t5_irq_n", {31'd0, irq_n}, 32'd0);
    check("t5_sb_empty", exp_q.size(), 0);
    cpu_wr(3'd7, 8'h02);
    #1;
    check("t5_irq_clr", {31'd0, irq_n}, 32'd1);
    rd_chk("t5_status_clr", 3'd7, 8'h00);

`ifdef DMA_CHANNEL_FILL_EN
    // Fill mode: writes of SRC_L, no reads.
    r0 = n_rd;
    exp_op(1, 0, 16'h9000, 8'hA5); exp_op(1, 0, 16'h9001, 8'hA5);
    prog(16'h00A5, 16'h9000, 16'd2, 8'h51);
    wait_idle("t6");
    check("t6_no_reads", n_rd, r0);
    check("t6_sb_empty", exp_q.size(), 0);
    rd_chk("t6_src_l", 3'd0, 8'hA5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/dma_channel_ctrl.md
Name: dma_channel_ctrl

Overview:
- CPU-programmable channel sequencer sitting directly upstream of `simpledma`.
- The Z80 loads source, destination and length through I/O-mapped registers, then sets START.
- The block requests the bus through `en_n` and feeds the DMA engine a stream of single-byte read/write ops over a valid/ready handshake, one read op then one write op per byte.
- It counts bytes, advances addresses, releases the bus and flags completion or raises an interrupt.

Parameters:
- ADDR_W, 16, address width of src/dst pointers and op_addr
- LEN_W, 16, width of the byte counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- cpu_cs_n  in  1  decoded I/O select for this channel's 8-register window
- cpu_wr_n  in  1  CPU write strobe, active low
- cpu_rd_n  in  1  CPU read strobe, active low
- cpu_addr  in  3  register index
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  register read data; 8'h00 when not selected
- busak_n  in  1  Z80 bus acknowledge
- en_n  out  1  channel owns transfer (drives engine enable / busrq), active low
- op_valid  out  1  op descriptor valid
- op_ready  in  1  engine accepts op
- op_addr  out  ADDR_W  op address
- op_data  out  8  write data (write ops only)
- op_write  out  1  1 = write op, 0 = read op
- op_io  out  1  1 = I/O cycle, 0 = memory cycle
- rd_valid  in  1  engine returns read data, single-cycle pulse
- rd_data  in  8  returned read byte
- irq_n  out  1  completion interrupt, active low, level

Behaviour:
- Reset values:
  - all registers 0; state IDLE
  - en_n=1, op_valid=0, op_addr=0, op_data=0, op_write=0, op_io=0, irq_n=1, cpu_dout=0
- Register map:
  - 0 SRC_L, 1 SRC_H, 2 DST_L, 3 DST_H, 4 LEN_L, 5 LEN_H
  - 6 CTRL: b0 START, b1 SRC_IO, b2 DST_IO, b3 SRC_INC, b4 DST_INC, b5 IRQ_EN, b6 FILL (optional), b7 ABORT
  - 7 STATUS: b0 BUSY, b1 DONE, b2 ABORTED
- CPU access:
  - A write is captured on the clk edge where cs_n=0 and wr_n=0, once per strobe; it is edge-detected on the falling edge of wr_n.
  - START and ABORT are self-clearing pulses and read back 0.
  - Writing STATUS with b1=1 clears DONE and ABORTED, and deasserts irq_n.
  - Writes to regs 0-5 while BUSY are ignored.
  - Reads are combinational from the live working pointers and counter.
- State machine:
  - IDLE: on START:
    - LEN=0 → DONE directly, no bus request;
    - otherwise → REQ.
  - REQ: en_n=0; wait for busak_n=0 → RD.
  - RD: op_valid=1, op_write=0, op_addr=src, op_io=SRC_IO; on op_valid&op_ready → WAIT_RD.
  - WAIT_RD: on rd_valid, latch rd_data → WR.
  - WR: op_valid=1, op_write=1, op_addr=dst, op_data=latched byte, op_io=DST_IO; on handshake → NEXT.
  - NEXT:
    - len <= len-1;
    - src += SRC_INC, dst += DST_INC (mod 2^ADDR_W, wrap FFFF→0000);
    - if the new len is 0 → DONE, else → RD.
    - en_n stays 0 across bytes; the bus is held for the whole block.
  - DONE: en_n=1, BUSY=0, DONE=1, irq_n=0 if IRQ_EN → IDLE.
- Handshake rules:
  - op fields are stable while op_valid=1 and op_ready=0.
  - op_valid never drops without a handshake, except on ABORT or reset.
- Boundary conditions:
  - busak_n deasserting mid-transfer: hold the current state and op_valid; resume when it reasserts.
  - ABORT in any non-IDLE state: op_valid=0, en_n=1 next cycle, ABORTED=1, DONE=1, IRQ as for DONE. Pointers and len keep their partial values.
  - START while BUSY is ignored.
  - Reset mid-operation returns everything to reset values within one cycle.
- Throughput: minimum 4 cycles per byte plus engine latency; 1 cycle REQ→RD after busak_n.

Optional Feature:
- DMA_CHANNEL_FILL_EN defined:
  - CTRL b6 FILL enables fill mode; SRC_L holds the fill byte.
  - Sequence is IDLE→REQ→WR→NEXT; no read ops issued; src pointers not advanced.
- Undefined:
  - CTRL b6 reads back 0 and is ignored.
  - The fill datapath is absent.

Decomposition:
- Shared package `dma_pkg`:
  - state enum encoding (IDLE, REQ, RD, WAIT_RD, WR, NEXT, DONE)
  - register index constants
  - CTRL/STATUS bit-position constants
- One natural sub-module, `dma_regfile`: CPU strobe edge-detect, register storage, read mux.
- The sequencer FSM and pointer/counter update stay in the top.

Test Plan:
- SRC=0x4000, DST=0x8000, LEN=3, SRC_INC=DST_INC=1, START; engine returns 0x11,0x22,0x33 → writes to 0x8000-0x8002 with those bytes; en_n low throughout; DONE=1; STATUS reads 0x02.
- LEN=0, START → no en_n assertion, DONE=1 next cycle, zero ops.
- SRC=0xFFFF, LEN=2, SRC_INC=1 → read addrs 0xFFFF then 0x0000 (wrap).
- op_ready held low 5 cycles in WR → op_addr/op_data/op_write stable; exactly one write counted.
- ABORT after first byte of LEN=4 → en_n=1 next cycle, STATUS=0x06, LEN readback 3, irq_n=0 with IRQ_EN; STATUS write 0x02 → irq_n=1.
- DMA_CHANNEL_FILL_EN, FILL=1, SRC_L=0xA5, DST=0x9000, LEN=2 → two writes of 0xA5 to 0x9000/0x9001; no read ops.
